// File: rtl/bram_loader.sv
// Streams a byte image into a single-port 8-bit BRAM, reads it back to verify
// an additive checksum, and otherwise passes the BRAM bus through to the CPU.
module bram_loader #(
  parameter int               ADDRW = 8,
  parameter logic [ADDRW-1:0] BASE  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [7:0]       cpu_wdata,
  output logic [7:0]       cpu_rdata,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  inout  wire  [7:0]       mem_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ADDRW:0]   length,
  output logic [7:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  localparam logic [ADDRW-1:0] TOP = '1;

  state_t           state;
  logic [ADDRW-1:0] wptr, rptr;
  logic [ADDRW:0]   vcnt;
  logic             rd_vld, overflow;
  logic [7:0]       vsum, vsum_nxt, wdat;
  logic             cpu_side, hs;

  assign cpu_side  = (state == IDLE) || (state == DONE);
  assign s_ready   = (state == LOAD);
  assign hs        = s_valid && s_ready;
  assign vsum_nxt  = vsum + mem_data;
  assign cpu_rdata = (cpu_side && !cpu_we) ? mem_data : 8'h00;
  assign mem_data  = mem_we ? wdat : 8'hzz;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = cpu_addr;
    wdat     = cpu_wdata;
    case (state)
      LOAD: begin
        mem_we   = s_valid;
        mem_addr = wptr;
        wdat     = s_data;
      end
      VERIFY: mem_addr = rptr;
      default: mem_we = cpu_we;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= BASE;
      rptr     <= BASE;
      vcnt     <= '0;
      rd_vld   <= 1'b0;
      vsum     <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      length   <= '0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state    <= LOAD;
          busy     <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
          overflow <= 1'b0;
          length   <= '0;
          checksum <= '0;
          wptr     <= BASE;
        end
        LOAD: if (hs) begin
          wptr     <= wptr + 1'b1;
          length   <= length + 1'b1;
          checksum <= checksum + s_data;
          // The top address ends the load; no wrap back to zero.
          if (s_last || wptr == TOP) begin
            state    <= VERIFY;
            overflow <= !s_last;
            rptr     <= BASE;
            vcnt     <= '0;
            rd_vld   <= 1'b0;
            vsum     <= '0;
          end
        end
        VERIFY: begin
          vcnt   <= vcnt + 1'b1;
          rd_vld <= (vcnt != length);
          if (vcnt != length) rptr <= rptr + 1'b1;
          if (rd_vld) vsum <= vsum_nxt;
          // Final cycle folds in the last read byte before comparing.
          if (vcnt == length) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= overflow | (vsum_nxt != checksum);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader with a behavioural single-port BRAM per instance.
module tb_bram_loader;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // instance 1: BASE = 0
  logic          start = 0, s_valid = 0, s_last = 0, cpu_we = 0;
  logic [7:0]    s_data = 0, cpu_wdata = 0;
  logic [AW-1:0] cpu_addr = 0;
  wire           s_ready, mem_we, busy, done, error;
  wire [7:0]     cpu_rdata, checksum, mem_data;
  wire [AW-1:0]  mem_addr;
  wire [AW:0]    length;

  // instance 2: BASE = 0xFE
  logic          start2 = 0, s_valid2 = 0, s_last2 = 0, cpu_we2 = 0;
  logic [7:0]    s_data2 = 0, cpu_wdata2 = 0;
  logic [AW-1:0] cpu_addr2 = 0;
  wire           s_ready2, mem_we2, busy2, done2, error2;
  wire [7:0]     cpu_rdata2, checksum2, mem_data2;
  wire [AW-1:0]  mem_addr2;
  wire [AW:0]    length2;

  bram_loader #(.ADDRW(AW), .BASE(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
    .error(error), .length(length), .checksum(checksum));

  bram_loader #(.ADDRW(AW), .BASE(8'hFE)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .s_last(s_last2), .cpu_we(cpu_we2), .cpu_addr(cpu_addr2),
    .cpu_wdata(cpu_wdata2), .cpu_rdata(cpu_rdata2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .busy(busy2), .done(done2),
    .error(error2), .length(length2), .checksum(checksum2));

  // BRAM models with a bench poke port
  logic [7:0] mem  [0:255];
  logic [7:0] mem2 [0:255];
  logic [7:0] rdat = 0, rdat2 = 0;
  logic       poke_en = 0, poke_en2 = 0;
  logic [7:0] poke_addr = 0, poke_data = 0, poke_addr2 = 0, poke_data2 = 0;
  int         wr_cnt = 0;

  assign mem_data  = mem_we  ? 8'hzz : rdat;
  assign mem_data2 = mem_we2 ? 8'hzz : rdat2;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
    rdat <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we2) mem2[mem_addr2] <= mem_data2;
    if (poke_en2) mem2[poke_addr2] <= poke_data2;
    rdat2 <= mem2[mem_addr2];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1; tick; start = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    #3;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || s_ready !== 1'b0) begin
      failed++; $display("FAIL reset_flags busy=%b done=%b error=%b s_ready=%b want 0000", busy, done, error, s_ready); end
    tests++; if (length !== 9'd0 || checksum !== 8'h00) begin
      failed++; $display("FAIL reset_counts length=%0d checksum=%h want 0/00", length, checksum); end
    tick; rst = 0; tick;
    cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
    #1;
    tests++; if (mem_we !== 1'b1 || mem_addr !== 8'h10) begin
      failed++; $display("FAIL cpu_pass mem_we=%b mem_addr=%h want 1/10", mem_we, mem_addr); end
    tick;
    cpu_we = 0;
    tick;
    tests++; if (cpu_rdata !== 8'h5A) begin
      failed++; $display("FAIL cpu_read got %h want 5a", cpu_rdata); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      failed++; $display("FAIL cpu_idle busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_basic;
    int n;
    pulse_start;
    tests++; if (busy !== 1'b1 || s_ready !== 1'b1 || cpu_rdata !== 8'h00) begin
      failed++; $display("FAIL load_entry busy=%b s_ready=%b cpu_rdata=%h want 1/1/00", busy, s_ready, cpu_rdata); end
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = 8'(i + 1); s_last = (i == 3); tick;
    end
    s_valid = 0; s_last = 0;
    tests++; if (mem_we !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      failed++; $display("FAIL verify_entry mem_we=%b s_ready=%b busy=%b want 0/0/1", mem_we, s_ready, busy); end
    n = 0;
    while (!done && n < 50) begin tick; n++; end
    tests++; if (n !== 5) begin
      failed++; $display("FAIL verify_len got %0d cycles want 5", n); end
    tests++; if (length !== 9'd4 || checksum !== 8'h0A || error !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL basic_result length=%0d checksum=%h error=%b busy=%b want 4/0a/0/0", length, checksum, error, busy); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[i] !== 8'(i + 1)) begin
        failed++; $display("FAIL basic_mem[%0d] got %h want %h", i, mem[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_gaps;
    int n, w0, d;
    logic pat [8];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      poke_en = 1; poke_addr = 8'(i); poke_data = 8'h00; tick;
    end
    poke_en = 0;
    w0 = wr_cnt;
    pulse_start;
    tests++; if (done !== 1'b0 || error !== 1'b0 || length !== 9'd0 || checksum !== 8'h00) begin
      failed++; $display("FAIL restart_clear done=%b error=%b length=%0d checksum=%h want 0/0/0/00", done, error, length, checksum); end
    d = 0;
    for (int k = 0; k < 8; k++) begin
      s_valid = pat[k];
      if (pat[k]) d++;
      s_data = 8'(d);
      s_last = pat[k] && (d == 4);
      #1;
      if (!pat[k]) begin
        tests++; if (mem_we !== 1'b0) begin
          failed++; $display("FAIL gap_we cycle %0d mem_we=%b want 0", k, mem_we); end
      end
      tick;
    end
    s_valid = 0; s_last = 0;
    n = 0;
    while (!done && n < 50) begin tick; n++; end
    tests++; if (n !== 5 || wr_cnt - w0 !== 4) begin
      failed++; $display("FAIL gap_counts verify=%0d writes=%0d want 5/4", n, wr_cnt - w0); end
    tests++; if (length !== 9'd4 || checksum !== 8'h0A || error !== 1'b0) begin
      failed++; $display("FAIL gap_result length=%0d checksum=%h error=%b want 4/0a/0", length, checksum, error); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[i] !== 8'(i + 1)) begin
        failed++; $display("FAIL gap_mem[%0d] got %h want %h", i, mem[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_overflow;
    int n;
    poke_en2 = 1; poke_addr2 = 8'h00; poke_data2 = 8'h11; tick; poke_en2 = 0;
    start2 = 1; tick; start2 = 0;
    s_valid2 = 1; s_last2 = 0;
    s_data2 = 8'hAA; tick;
    s_data2 = 8'hBB; tick;
    s_data2 = 8'hCC; #1;
    tests++; if (s_ready2 !== 1'b0 || mem_we2 !== 1'b0) begin
      failed++; $display("FAIL ovf_third s_ready=%b mem_we=%b want 0/0", s_ready2, mem_we2); end
    n = 0;
    while (!done2 && n < 50) begin tick; n++; end
    s_valid2 = 0;
    tests++; if (n !== 3) begin
      failed++; $display("FAIL ovf_verify_len got %0d want 3", n); end
    tests++; if (length2 !== 9'd2 || checksum2 !== 8'h65 || error2 !== 1'b1 || done2 !== 1'b1) begin
      failed++; $display("FAIL ovf_result length=%0d checksum=%h error=%b done=%b want 2/65/1/1", length2, checksum2, error2, done2); end
    tests++; if (mem2[8'hFE] !== 8'hAA || mem2[8'hFF] !== 8'hBB || mem2[0] !== 8'h11) begin
      failed++; $display("FAIL ovf_mem fe=%h ff=%h 00=%h want aa/bb/11", mem2[8'hFE], mem2[8'hFF], mem2[0]); end
  endtask

  task automatic test_corrupt;
    int n;
    pulse_start;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = 8'(16 * (i + 1)); s_last = (i == 2); tick;
    end
    s_valid = 0; s_last = 0;
    poke_en = 1; poke_addr = 8'h02; poke_data = 8'h99; tick; poke_en = 0;
    n = 1;
    while (!done && n < 50) begin tick; n++; end
    tests++; if (n !== 4 || error !== 1'b1) begin
      failed++; $display("FAIL corrupt verify=%0d error=%b want 4/1", n, error); end
    tests++; if (length !== 9'd3 || checksum !== 8'h60) begin
      failed++; $display("FAIL corrupt_sum length=%0d checksum=%h want 3/60", length, checksum); end
  endtask

  task automatic test_rst_mid_load;
    pulse_start;
    s_valid = 1; s_data = 8'h77; tick;
    s_data = 8'h88; tick;
    s_valid = 0;
    #2 rst = 1;
    #1;
    tests++; if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      failed++; $display("FAIL rst_async_flags busy=%b s_ready=%b done=%b error=%b want 0000", busy, s_ready, done, error); end
    tests++; if (length !== 9'd0 || checksum !== 8'h00) begin
      failed++; $display("FAIL rst_async_counts length=%0d checksum=%h want 0/00", length, checksum); end
    tick; rst = 0; tick;
    tests++; if (mem[0] !== 8'h77 || mem[1] !== 8'h88) begin
      failed++; $display("FAIL rst_retain m0=%h m1=%h want 77/88", mem[0], mem[1]); end
  endtask

  task automatic test_start_busy;
    int n;
    pulse_start;
    s_valid = 1; s_data = 8'h05; tick;
    s_data = 8'h06; tick;
    s_valid = 0;
    pulse_start;
    tests++; if (busy !== 1'b1 || s_ready !== 1'b1 || length !== 9'd2) begin
      failed++; $display("FAIL start_in_load busy=%b s_ready=%b length=%0d want 1/1/2", busy, s_ready, length); end
    s_valid = 1; s_data = 8'h07; s_last = 1; tick;
    s_valid = 0; s_last = 0;
    pulse_start;
    tests++; if (busy !== 1'b1 || s_ready !== 1'b0 || length !== 9'd3) begin
      failed++; $display("FAIL start_in_verify busy=%b s_ready=%b length=%0d want 1/0/3", busy, s_ready, length); end
    n = 1;
    while (!done && n < 50) begin tick; n++; end
    tests++; if (n !== 4 || length !== 9'd3 || checksum !== 8'h12 || error !== 1'b0) begin
      failed++; $display("FAIL busy_result verify=%0d length=%0d checksum=%h error=%b want 4/3/12/0", n, length, checksum, error); end
    tests++; if (mem[2] !== 8'h07) begin
      failed++; $display("FAIL busy_mem got %h want 07", mem[2]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_overflow;
    test_corrupt;
    test_rst_mid_load;
    test_start_busy;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Upstream stage of the 8-bit single-port BRAM: owns the BRAM's addr/we/bidirectional data bus.
- Streams a byte image (valid/ready) into consecutive BRAM addresses, then reads the region back and verifies an 8-bit additive checksum.
- Hands the bus to the CPU side when idle or done. Used to boot 6502 program memory without a rebuild.

Parameters:
- ADDRW, 8, BRAM address width; region size 2^ADDRW bytes.
- BASE, 0, first load address (ADDRW bits).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts a byte.
- s_data  in  8  stream byte.
- s_last  in  1  marks final byte of the image.
- cpu_we  in  1  CPU write strobe; CPU side reads when 0.
- cpu_addr  in  ADDRW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data.
- mem_we  out  1  BRAM we (1 = write).
- mem_addr  out  ADDRW  BRAM address.
- mem_data  inout  8  BRAM data bus; driven by the loader only while mem_we=1, else high-Z.
- busy  out  1  high in LOAD/VERIFY.
- done  out  1  sticky; high in DONE.
- error  out  1  sticky; valid when done=1.
- length  out  ADDRW+1  bytes accepted in the last load.
- checksum  out  8  running sum of the loaded bytes.

Behaviour:
- BRAM timing:
  - Write occurs on the clk edge where mem_we=1.
  - Read: address presented in cycle N with mem_we=0; data is valid on mem_data in cycle N+1, provided mem_we stays 0.
- Reset (async): state=IDLE.
  - s_ready=0, busy=0, done=0, error=0.
  - length=0, checksum=0, internal pointers=BASE.
  - BRAM contents are untouched. Reset mid-LOAD or mid-VERIFY aborts immediately to IDLE.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE/DONE (CPU passthrough):
  - mem_we=cpu_we, mem_addr=cpu_addr.
  - mem_data driven with cpu_wdata when cpu_we=1.
  - cpu_rdata=mem_data when cpu_we=0, else 0.
  - s_ready=0.
- start in IDLE/DONE -> LOAD next cycle:
  - clear done, error, overflow, length, checksum.
  - wptr=BASE.
- LOAD:
  - s_ready=1. mem_we=s_valid, mem_addr=wptr, mem_data=s_data (combinational).
  - CPU side ignored; cpu_rdata=0.
  - Each handshake (s_valid&s_ready): wptr+1, length+1, checksum+=s_data mod 256.
  - Exit to VERIFY after the handshake that has s_last=1.
  - Exit to VERIFY after the handshake at address 2^ADDRW-1; if s_last=0 on that beat, set overflow. No wrap-around.
  - Idle cycles (s_valid=0) hold all state.
- VERIFY:
  - s_ready=0, mem_we=0.
  - rptr starts at BASE and advances 1 per cycle for length cycles.
  - A one-cycle-delayed valid accumulates vsum+=mem_data.
  - Total duration is length+1 cycles.
  - Then error=overflow | (vsum!=checksum); go to DONE.
  - length=0 is impossible (LOAD exits only on a handshake).
- DONE: done=1; error and length hold until the next start.
- Ignored inputs:
  - start while busy: ignored.
  - s_valid outside LOAD: ignored.
  - s_last on a non-handshake cycle: ignored.

Test Plan:
- Reset, then CPU writes 0x5A at 0x10 and reads it back -> cpu_rdata=0x5A one cycle after the read address; busy=0, done=0.
- start; stream 01,02,03,04 (s_last on 04), BASE=0 -> BRAM[0..3]=01..04; length=4, checksum=0x0A; VERIFY lasts 5 cycles; done=1, error=0.
- Stream 4 bytes with s_valid gaps of 1 and 3 cycles -> identical memory and checksum to the gapless case; no write on gap cycles.
- BASE=0xFE, stream 3 bytes without s_last -> writes at 0xFE and 0xFF only; third byte not accepted (s_ready=0); length=2; done=1, error=1 (overflow).
- During VERIFY, force one BRAM byte to a different value through a bench hook -> error=1. Assert rst mid-LOAD -> outputs return to reset values asynchronously; already-written bytes are retained.
- start pulsed while busy -> no restart and length unchanged; start in DONE -> new load, done and error cleared the next cycle.
